// File: rtl/scp_pkg.sv
// Shared definitions for the SCP instruction encoder: opcodes, command kinds, FSM states.
package scp_pkg;

    // Primary opcode field values (instruction bits [31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBneq  = 6'b000101;
    localparam logic [5:0] OpBgtz  = 6'b000111;
    localparam logic [5:0] OpAddi  = 6'b001000;

    typedef enum logic [2:0] {
        KindRtype   = 3'd0,
        KindLw      = 3'd1,
        KindSw      = 3'd2,
        KindBeq     = 3'd3,
        KindBneq    = 3'd4,
        KindBgtz    = 3'd5,
        KindAddi    = 3'd6,
        KindIllegal = 3'd7
    } cmd_kind_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } scp_state_e;

endpackage

// File: rtl/scp_inst_pack.sv
// Combinational instruction packer: command kind and fields in, 32-bit word out.
module scp_inst_pack
    import scp_pkg::*;
(
    input  cmd_kind_e   kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  func_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the instruction format and opcode for the command kind
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KindRtype:   word_o = {OpRtype, rs_i, rt_i, rd_i, 5'b00000, func_i};
            KindLw:      word_o = {OpLw, rs_i, rt_i, imm_i};
            KindSw:      word_o = {OpSw, rs_i, rt_i, imm_i};
            KindBeq:     word_o = {OpBeq, rs_i, rt_i, imm_i};
            KindBneq:    word_o = {OpBneq, rs_i, rt_i, imm_i};
            // bgtz compares rs against zero only, so rt is architecturally zero
            KindBgtz:    word_o = {OpBgtz, rs_i, 5'b00000, imm_i};
            KindAddi:    word_o = {OpAddi, rs_i, rt_i, imm_i};
            KindIllegal: illegal_o = 1'b1;
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/scp_inst_encoder.sv
// Instruction encoder: accepts decoded commands and writes encoded words to instruction memory.
// Optional feature: define SCP_ENC_CHECKSUM_EN to keep a running XOR of written words.
module scp_inst_encoder
    import scp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_kind,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [5:0]  cmd_func,
    input  logic [15:0] cmd_imm,
    input  logic        cmd_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [10:0] count,
    output logic        err_illegal,
    output logic        err_overflow,
    output logic [31:0] checksum
);

    scp_state_e  state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [10:0] count_q;
    logic        err_ill_q;
    logic        err_ovf_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [31:0] inflight;
    logic        accept;

    scp_inst_pack u_pack (
        .kind_i    (cmd_kind_e'(cmd_kind)),
        .rs_i      (cmd_rs),
        .rt_i      (cmd_rt),
        .rd_i      (cmd_rd),
        .func_i    (cmd_func),
        .imm_i     (cmd_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Words written plus a write still pending; keeps back-to-back accepts within MAX_WORDS
    assign inflight  = 32'(count_q) + 32'(we_q);
    assign cmd_ready = (state_q == StLoad) && (inflight < MAX_WORDS);
    assign accept    = cmd_valid && cmd_ready;

    // Session FSM plus the registered write port, counters and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            count_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            we_q <= accept;
            if (accept) begin
                wdata_q <= enc_word;
                if (enc_illegal) begin
                    err_ill_q <= 1'b1;
                end
            end
            // A write completes this cycle: step to the next word slot
            if (we_q) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 11'd1;
            end
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StLoad;
                        addr_q    <= BASE_ADDR;
                        count_q   <= '0;
                        err_ill_q <= 1'b0;
                        err_ovf_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept && cmd_last) begin
                        state_q <= StDone;
                    end else if (we_q && (32'(count_q) + 32'd1 == MAX_WORDS)) begin
                        state_q   <= StDone;
                        err_ovf_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset also masks a write already in flight so nothing reaches memory
    assign imem_we      = we_q && !reset;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = (state_q == StLoad);
    assign done         = (state_q == StDone);
    assign count        = count_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;

`ifdef SCP_ENC_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Running XOR of every word written this session
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (start && (state_q != StLoad)) begin
            checksum_q <= '0;
        end else if (we_q) begin
            checksum_q <= checksum_q ^ wdata_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_scp_inst_encoder.sv
// Self-checking bench for scp_inst_encoder: directed cases plus randomized sessions
// against a transaction-level reference model.
module tb_scp_inst_encoder;

    localparam logic [31:0] Base      = 32'h0000_0000;
    localparam logic [31:0] SmallBase = 32'hFFFF_FFFC;
    localparam int unsigned MaxWords  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cmd_valid, cmd_last, start_s, cmd_valid_s;
    logic [2:0]  cmd_kind;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [5:0]  cmd_func;
    logic [15:0] cmd_imm;

    logic        cmd_ready, imem_we, busy, done, err_illegal, err_overflow;
    logic [31:0] imem_addr, imem_wdata, checksum;
    logic [10:0] count;
    logic        cmd_ready_s, imem_we_s, busy_s, done_s, err_illegal_s, err_overflow_s;
    logic [31:0] imem_addr_s, imem_wdata_s, checksum_s;
    logic [10:0] count_s;

    scp_inst_encoder u_dut (
        .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_func(cmd_func), .cmd_imm(cmd_imm), .cmd_last(cmd_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .count(count), .err_illegal(err_illegal), .err_overflow(err_overflow),
        .checksum(checksum)
    );

    scp_inst_encoder #(.BASE_ADDR(SmallBase), .MAX_WORDS(2)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .cmd_valid(cmd_valid_s),
        .cmd_ready(cmd_ready_s), .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_rd(cmd_rd), .cmd_func(cmd_func), .cmd_imm(cmd_imm), .cmd_last(cmd_last),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
        .busy(busy_s), .done(done_s), .count(count_s), .err_illegal(err_illegal_s),
        .err_overflow(err_overflow_s), .checksum(checksum_s)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_s_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    // Reference model state: 0 idle, 1 loading, 2 done
    int          m_mode = 0;
    int unsigned m_acc = 0;
    logic        m_ill = 1'b0;
    logic [31:0] m_csum = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Instruction word from the ISA field layout
    function automatic logic [31:0] encode(input int kind, input int rs, input int rt,
                                           input int rd, input int func, input int imm);
        int unsigned op;
        int unsigned rt_eff;
        rt_eff = rt;
        case (kind)
            0: return (rs << 21) | (rt << 16) | (rd << 11) | func;
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 5;
            5: begin op = 7; rt_eff = 0; end
            6: op = 8;
            default: return 32'h0;
        endcase
        return (op << 26) | (rs << 21) | (rt_eff << 16) | imm;
    endfunction

    // Advance one clock and score any write seen on either DUT
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (exp_q.size() == 0) check("spurious_we", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", imem_wdata, e.data);
            end
        end
        if (imem_we_s) begin
            if (exp_s_q.size() == 0) check("spurious_we_small", 32'd1, 32'd0);
            else begin
                e = exp_s_q.pop_front();
                check("wr_addr_small", imem_addr_s, e.addr);
                check("wr_data_small", imem_wdata_s, e.data);
            end
        end
    endtask

    task automatic set_fields(input int kind, input int rs, input int rt, input int rd,
                              input int func, input int imm, input bit last);
        cmd_kind = 3'(kind);
        cmd_rs   = 5'(rs);
        cmd_rt   = 5'(rt);
        cmd_rd   = 5'(rd);
        cmd_func = 6'(func);
        cmd_imm  = 16'(imm);
        cmd_last = last;
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_mode != 1) begin
            m_mode = 1;
            m_acc  = 0;
            m_ill  = 1'b0;
            m_csum = '0;
            check("start_count", 32'(count), 32'd0);
            check("start_addr", imem_addr, Base);
            check("start_err_ill", 32'(err_illegal), 32'd0);
            check("start_err_ovf", 32'(err_overflow), 32'd0);
        end
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Offer one command for one cycle; the model decides whether it is taken
    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int func, input int imm, input bit last,
                        input logic [31:0] exp_word);
        set_fields(kind, rs, rt, rd, func, imm, last);
        cmd_valid = 1'b1;
        if (m_mode == 1 && m_acc < MaxWords) begin
            check("cmd_ready", 32'(cmd_ready), 32'd1);
            exp_q.push_back('{addr: Base + 32'(4 * m_acc), data: exp_word});
            m_acc++;
            m_csum ^= exp_word;
            if (kind == 7) m_ill = 1'b1;
            if (last) m_mode = 2;
        end else begin
            check("cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        tick();
    endtask

    task automatic expect_done();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("end_count", 32'(count), 32'(m_acc));
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(cmd_ready), 32'd0);
        check("end_err_ill", 32'(err_illegal), 32'(m_ill));
        check("end_err_ovf", 32'(err_overflow), 32'd0);
        check("end_pending", 32'(exp_q.size()), 32'd0);
`ifdef SCP_ENC_CHECKSUM_EN
        check("end_checksum", checksum, m_csum);
`else
        check("end_checksum", checksum, 32'd0);
`endif
    endtask

    task automatic check_reset_state();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, Base);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err_ill", 32'(err_illegal), 32'd0);
        check("rst_err_ovf", 32'(err_overflow), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_addr_small", imem_addr_s, SmallBase);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; start_s = 1'b0; cmd_valid_s = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        // addi with last: single write then done
        start_session();
        send(6, 0, 8, 0, 0, 5, 1'b1, 32'h2008_0005);
        check("addi_done", 32'(done), 32'd1);
        expect_done();

        // R-type then lw back-to-back
        start_session();
        send(0, 9, 10, 8, 32, 0, 1'b0, 32'h012A_4020);
        send(1, 29, 8, 0, 0, 4, 1'b1, 32'h8FA8_0004);
        expect_done();

        // bgtz forces rt to zero; illegal kind writes zero and stays flagged
        start_session();
        send(5, 4, 7, 0, 0, 16'hFFFE, 1'b0, 32'h1C80_FFFE);
        send(7, 3, 3, 3, 3, 3, 1'b0, 32'h0000_0000);
        cmd_valid = 1'b0;
        tick();
        check("ill_set", 32'(err_illegal), 32'd1);
        send(6, 1, 2, 0, 0, 1, 1'b1, 32'h2022_0001);
        expect_done();
        start_session();
        check("ill_cleared", 32'(err_illegal), 32'd0);
        send(2, 5, 6, 0, 0, 8, 1'b1, 32'hACA6_0008);
        expect_done();

        // Overflow on the two-word instance, addresses wrap past 2^32
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        set_fields(6, 1, 2, 0, 0, 3, 1'b0);
        cmd_valid_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                check("small_ready", 32'(cmd_ready_s), 32'd1);
                exp_s_q.push_back('{addr: SmallBase + 32'(4 * i), data: 32'h2022_0003});
            end else begin
                check("small_ready_full", 32'(cmd_ready_s), 32'd0);
            end
            tick();
        end
        cmd_valid_s = 1'b0;
        tick();
        tick();
        check("ovf_flag", 32'(err_overflow_s), 32'd1);
        check("ovf_ready", 32'(cmd_ready_s), 32'd0);
        check("ovf_done", 32'(done_s), 32'd1);
        check("ovf_count", 32'(count_s), 32'd2);
        check("ovf_pending", 32'(exp_s_q.size()), 32'd0);

        // Randomized sessions with idle gaps and ignored mid-session starts
        for (int s = 0; s < 20; s++) begin
            int n;
            n = $urandom_range(1, 10);
            start_session();
            for (int i = 0; i < n; i++) begin
                int k, rs, rt, rd, fn, im;
                k  = $urandom_range(0, 7);
                rs = $urandom_range(0, 31);
                rt = $urandom_range(0, 31);
                rd = $urandom_range(0, 31);
                fn = $urandom_range(0, 63);
                im = $urandom_range(0, 65535);
                send(k, rs, rt, rd, fn, im, i == n - 1, encode(k, rs, rt, rd, fn, im));
                if (i < n - 1 && $urandom_range(0, 2) == 0) begin
                    cmd_valid = 1'b0;
                    start = ($urandom_range(0, 1) == 0);
                    tick();
                    start = 1'b0;
                    check("gap_busy", 32'(busy), 32'd1);
                end
            end
            expect_done();
        end

        // Reset right after an accept suppresses the pending write
        start_session();
        set_fields(6, 0, 8, 0, 0, 5, 1'b0);
        cmd_valid = 1'b1;
        check("rst_case_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        check("rst_we_suppressed", 32'(imem_we), 32'd0);
        exp_q.delete();
        m_mode = 0;
        tick();
        check_reset_state();
        reset = 1'b0;
        tick();
        check("post_rst_we", 32'(imem_we), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
